// File: rtl/series_slice_ctrl_pkg.sv
// Shared types and constants for the series slice sequencer.
package series_slice_ctrl_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    // Default operand/sum width (Q1.31)
    localparam int DATA_W_DEF = 32;

    // Q1.31 reference constants
    localparam logic [31:0] ONE      = 32'h7FFF_FFFF;
    localparam logic [31:0] NEG_HALF = 32'hC000_0000;

endpackage

// File: rtl/series_slice_ctrl.sv
// Iterative sequencer that runs one external datapath slice TERMS times per
// operand, owning the x/num/sum/overflow feedback registers between passes.
module series_slice_ctrl
    import series_slice_ctrl_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int TERMS      = 4,
    parameter int ADDR_W     = 2,
    parameter int SLICE_LAT  = 0,
    parameter int EARLY_EXIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_overflow,
    output logic [DATA_W-1:0] slc_x,
    output logic [DATA_W-1:0] slc_num,
    output logic [DATA_W-1:0] slc_sum,
    output logic [ADDR_W-1:0] slc_addr,
    output logic              slc_sel_sum,
    output logic              slc_overflow,
    input  logic [DATA_W-1:0] slc_out_x,
    input  logic [DATA_W-1:0] slc_out_num,
    input  logic [DATA_W-1:0] slc_out_sum,
    input  logic              slc_out_overflow
);

    localparam int WAIT_INIT = (SLICE_LAT > 0) ? SLICE_LAT - 1 : 0;
    localparam int WCNT_W    = (WAIT_INIT > 0) ? $clog2(WAIT_INIT + 1) : 1;

    state_t              state;
    logic [DATA_W-1:0]   x_reg;
    logic [DATA_W-1:0]   num_reg;
    logic [DATA_W-1:0]   sum_reg;
    logic                ovf_reg;
    logic [ADDR_W-1:0]   term;
    logic [WCNT_W-1:0]   wcnt;

    logic                capture;
    logic                new_ovf;
    logic                last_term;
    logic                finish;

    // Slice inputs come straight from the feedback registers
    assign slc_x        = x_reg;
    assign slc_num      = num_reg;
    assign slc_sum      = sum_reg;
    assign slc_addr     = term;
    assign slc_overflow = ovf_reg;
    assign slc_sel_sum  = ((state == S_ISSUE) || (state == S_WAIT)) && (term == '0);

    // Decide when the slice result is captured and whether the operand is finished
    always_comb begin
        capture   = 1'b0;
        if (state == S_ISSUE && SLICE_LAT == 0)
            capture = 1'b1;
        if (state == S_WAIT && wcnt == '0)
            capture = 1'b1;
        new_ovf   = ovf_reg | slc_out_overflow;
        last_term = (term == ADDR_W'(TERMS - 1));
        finish    = last_term || ((EARLY_EXIT != 0) && new_ovf);
    end

    // Sequencer FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_overflow <= 1'b0;
            x_reg        <= '0;
            num_reg      <= '0;
            sum_reg      <= '0;
            ovf_reg      <= 1'b0;
            term         <= '0;
            wcnt         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x_reg    <= in_x;
                        num_reg  <= in_x;
                        sum_reg  <= '0;
                        ovf_reg  <= 1'b0;
                        term     <= '0;
                        in_ready <= 1'b0;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (SLICE_LAT != 0) begin
                        wcnt  <= WCNT_W'(WAIT_INIT);
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wcnt != '0)
                        wcnt <= wcnt - 1'b1;
                end
                S_DONE: begin
                    // Result registers load on the first DONE cycle, so out_valid
                    // rises one clock after the final capture.
                    if (!out_valid) begin
                        out_valid    <= 1'b1;
                        out_sum      <= sum_reg;
                        out_overflow <= ovf_reg;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (capture) begin
                x_reg   <= slc_out_x;
                num_reg <= slc_out_num;
                sum_reg <= slc_out_sum;
                ovf_reg <= new_ovf;
                if (finish) begin
                    state <= S_DONE;
                end else begin
                    term  <= term + 1'b1;
                    state <= S_ISSUE;
                end
            end
        end
    end

endmodule

// File: tb/tb_series_slice_ctrl.sv
// Bench for series_slice_ctrl: three controller configurations, each driving a
// behavioural slice, checked cycle by cycle against a term-level model.
module tb_series_slice_ctrl;
    import series_slice_ctrl_pkg::*;

    localparam int NDUT = 3;
    localparam int NT   = 4;
    localparam int LAT_OF [NDUT] = '{0, 1, 0};
    localparam int EE_OF  [NDUT] = '{1, 1, 0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid     [NDUT];
    logic        in_ready     [NDUT];
    logic [31:0] in_x         [NDUT];
    logic        out_valid    [NDUT];
    logic        out_ready    [NDUT];
    logic [31:0] out_sum      [NDUT];
    logic        out_overflow [NDUT];
    logic [31:0] slc_x        [NDUT];
    logic [31:0] slc_num      [NDUT];
    logic [31:0] slc_sum      [NDUT];
    logic [1:0]  slc_addr     [NDUT];
    logic        slc_sel_sum  [NDUT];
    logic        slc_overflow [NDUT];
    logic [96:0] sl_o         [NDUT];
    logic [31:0] slc_out_x    [NDUT];
    logic [31:0] slc_out_num  [NDUT];
    logic [31:0] slc_out_sum  [NDUT];
    logic        slc_out_ovf  [NDUT];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // Behavioural slice: sum' = (sel ? 0 : sum) + num + addr, num' = num/2,
    // overflow when the signed 32-bit sum overflows. Returns {ovf,sum,num,x}.
    function automatic logic [96:0] slice_f(input logic [31:0] x, input logic [31:0] num,
                                            input logic [31:0] sum, input logic [1:0] addr,
                                            input logic sel);
        longint base;
        longint r;
        logic   ovf;
        logic [31:0] nn;
        base = sel ? 64'sd0 : longint'($signed(sum));
        r    = base + longint'($signed(num)) + longint'(addr);
        ovf  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        nn   = $signed(num) >>> 1;
        return {ovf, r[31:0], nn, x};
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_slice
        assign sl_o[g]        = slice_f(slc_x[g], slc_num[g], slc_sum[g], slc_addr[g], slc_sel_sum[g]);
        assign slc_out_x[g]   = sl_o[g][31:0];
        assign slc_out_num[g] = sl_o[g][63:32];
        assign slc_out_sum[g] = sl_o[g][95:64];
        assign slc_out_ovf[g] = sl_o[g][96];
    end

    series_slice_ctrl #(.DATA_W(32), .TERMS(NT), .ADDR_W(2), .SLICE_LAT(0), .EARLY_EXIT(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_x(in_x[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_sum(out_sum[0]),
        .out_overflow(out_overflow[0]), .slc_x(slc_x[0]), .slc_num(slc_num[0]),
        .slc_sum(slc_sum[0]), .slc_addr(slc_addr[0]), .slc_sel_sum(slc_sel_sum[0]),
        .slc_overflow(slc_overflow[0]), .slc_out_x(slc_out_x[0]), .slc_out_num(slc_out_num[0]),
        .slc_out_sum(slc_out_sum[0]), .slc_out_overflow(slc_out_ovf[0]));

    series_slice_ctrl #(.DATA_W(32), .TERMS(NT), .ADDR_W(2), .SLICE_LAT(1), .EARLY_EXIT(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_x(in_x[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_sum(out_sum[1]),
        .out_overflow(out_overflow[1]), .slc_x(slc_x[1]), .slc_num(slc_num[1]),
        .slc_sum(slc_sum[1]), .slc_addr(slc_addr[1]), .slc_sel_sum(slc_sel_sum[1]),
        .slc_overflow(slc_overflow[1]), .slc_out_x(slc_out_x[1]), .slc_out_num(slc_out_num[1]),
        .slc_out_sum(slc_out_sum[1]), .slc_out_overflow(slc_out_ovf[1]));

    series_slice_ctrl #(.DATA_W(32), .TERMS(NT), .ADDR_W(2), .SLICE_LAT(0), .EARLY_EXIT(0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_x(in_x[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_sum(out_sum[2]),
        .out_overflow(out_overflow[2]), .slc_x(slc_x[2]), .slc_num(slc_num[2]),
        .slc_sum(slc_sum[2]), .slc_addr(slc_addr[2]), .slc_sel_sum(slc_sel_sum[2]),
        .slc_overflow(slc_overflow[2]), .slc_out_x(slc_out_x[2]), .slc_out_num(slc_out_num[2]),
        .slc_out_sum(slc_out_sum[2]), .slc_out_overflow(slc_out_ovf[2]));

    task automatic chk(input int i, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %h expected %h at %0t", name, i, act, exp, $time);
    endtask

    // ---------------- term-level model ----------------
    logic        m_busy [NDUT];
    logic        m_zero [NDUT];
    int          m_cyc  [NDUT];
    int          m_k    [NDUT];
    logic [31:0] m_x    [NDUT];
    logic [31:0] m_sum  [NDUT];
    logic        m_ovf  [NDUT];
    logic [31:0] tr_num [NDUT][NT];
    logic [31:0] tr_sum [NDUT][NT];
    logic        tr_ovf [NDUT][NT];
    logic        chk_en = 1'b0;
    int          c_act;
    int          c_t;

    task automatic model_run(input int i, input logic [31:0] x);
        logic [31:0] num;
        logic [31:0] sum;
        logic        ovf;
        logic [96:0] r;
        num = x; sum = '0; ovf = 1'b0; m_k[i] = 0;
        for (int t = 0; t < NT; t++) begin
            tr_num[i][t] = num;
            tr_sum[i][t] = sum;
            tr_ovf[i][t] = ovf;
            r   = slice_f(x, num, sum, 2'(t), t == 0);
            sum = r[95:64];
            num = r[63:32];
            ovf = ovf | r[96];
            m_k[i] = t + 1;
            if (ovf && EE_OF[i] != 0) break;
        end
        m_x[i] = x; m_sum[i] = sum; m_ovf[i] = ovf;
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            m_busy[i] = 1'b0; m_zero[i] = 1'b0; m_cyc[i] = 0; m_k[i] = 1;
        end
    end

    // Compare every DUT against the model mid-cycle, then advance the model
    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (m_busy[i]) m_cyc[i]++;
            c_act = m_k[i] * (LAT_OF[i] + 1);
            if (chk_en) begin
                if (!m_busy[i]) begin
                    chk(i, "idle_in_ready", in_ready[i], 1);
                    chk(i, "idle_out_valid", out_valid[i], 0);
                    chk(i, "idle_sel_sum", slc_sel_sum[i], 0);
                    if (m_zero[i]) begin
                        chk(i, "rst_out_sum", out_sum[i], 0);
                        chk(i, "rst_out_ovf", out_overflow[i], 0);
                        chk(i, "rst_slc_x", slc_x[i], 0);
                        chk(i, "rst_slc_num", slc_num[i], 0);
                        chk(i, "rst_slc_sum", slc_sum[i], 0);
                        chk(i, "rst_slc_addr", slc_addr[i], 0);
                        chk(i, "rst_slc_ovf", slc_overflow[i], 0);
                    end
                end else begin
                    chk(i, "busy_in_ready", in_ready[i], 0);
                    if (m_cyc[i] <= c_act) begin
                        c_t = (m_cyc[i] - 1) / (LAT_OF[i] + 1);
                        chk(i, "term_out_valid", out_valid[i], 0);
                        chk(i, "term_addr", slc_addr[i], c_t);
                        chk(i, "term_sel_sum", slc_sel_sum[i], (c_t == 0) ? 1 : 0);
                        chk(i, "term_slc_x", slc_x[i], m_x[i]);
                        chk(i, "term_slc_num", slc_num[i], tr_num[i][c_t]);
                        chk(i, "term_slc_sum", slc_sum[i], tr_sum[i][c_t]);
                        chk(i, "term_slc_ovf", slc_overflow[i], tr_ovf[i][c_t]);
                    end else begin
                        chk(i, "done_sel_sum", slc_sel_sum[i], 0);
                        chk(i, "done_addr_bound", (int'(slc_addr[i]) < m_k[i]) ? 1 : 0, 1);
                        chk(i, "done_out_valid", out_valid[i], (m_cyc[i] >= c_act + 2) ? 1 : 0);
                        if (m_cyc[i] >= c_act + 2) begin
                            chk(i, "done_out_sum", out_sum[i], m_sum[i]);
                            chk(i, "done_out_ovf", out_overflow[i], m_ovf[i]);
                        end
                    end
                end
            end
            if (rst) begin
                m_busy[i] = 1'b0;
                m_zero[i] = 1'b1;
            end else if (!m_busy[i] && in_valid[i]) begin
                model_run(i, in_x[i]);
                m_busy[i] = 1'b1;
                m_zero[i] = 1'b0;
                m_cyc[i]  = 0;
            end else if (m_busy[i] && m_cyc[i] >= c_act + 2 && out_ready[i]) begin
                m_busy[i] = 1'b0;
            end
        end
        if (rst) chk_en = 1'b1;
    end

    // ---------------- directed stimulus ----------------
    task automatic run_op(input int i, input logic [31:0] x, input int hold,
                          input logic [31:0] exp_sum, input logic exp_ovf, input int exp_lat);
        int lat;
        in_valid[i] = 1'b1;
        in_x[i]     = x;
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
        lat = 0;
        while (!out_valid[i] && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        chk(i, "latency", lat, exp_lat);
        chk(i, "lit_out_sum", out_sum[i], exp_sum);
        chk(i, "lit_out_ovf", out_overflow[i], exp_ovf);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready[i] = 1'b1;
        @(posedge clk); #1;
        out_ready[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            in_valid[i] = 1'b0; in_x[i] = '0; out_ready[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // basic sequencing, slice latency 1, early exit, sticky overflow without exit
        run_op(0, 32'h4000_0000, 0, 32'h7800_0006, 1'b0, 5);
        run_op(1, 32'h4000_0000, 0, 32'h7800_0006, 1'b0, 9);
        run_op(0, ONE,           0, 32'hBFFF_FFFF, 1'b1, 3);
        run_op(2, ONE,           0, 32'hF000_0002, 1'b1, 5);

        // backpressure then back-to-back operand
        run_op(0, 32'h4000_0000, 3, 32'h7800_0006, 1'b0, 5);
        chk(0, "b2b_in_ready", in_ready[0], 1);
        run_op(0, NEG_HALF,      0, 32'h8800_0006, 1'b0, 5);

        // reset while dut1 is on term 2
        in_valid[1] = 1'b1;
        in_x[1]     = 32'h4000_0000;
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk(1, "pre_rst_addr", slc_addr[1], 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk(1, "post_rst_in_ready", in_ready[1], 1);
        chk(1, "post_rst_out_valid", out_valid[1], 0);
        chk(1, "post_rst_slc_sum", slc_sum[1], 0);
        run_op(1, NEG_HALF, 0, 32'h8800_0006, 1'b0, 9);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/series_slice_ctrl.md
Name: series_slice_ctrl

Overview:
Iterative sequencer that time-multiplexes a single pipe_slice_dp datapath slice across TERMS series terms.
- Accepts an operand x via a valid/ready handshake.
- Owns the x/num/sum/overflow feedback registers and drives the slice's coefficient address and sum-select each term.
- Returns the accumulated sum and a sticky overflow flag via a valid/ready handshake.
- Sits between the top-level control path and one slice instance; replaces a fully unrolled slice chain when area matters.

Parameters:
- DATA_W, 32, operand/sum width (Q1.31).
- TERMS, 4, number of slice passes per operand (≥1).
- ADDR_W, 2, coefficient address width; ceil(log2(TERMS)), minimum 1.
- SLICE_LAT, 0, slice input-to-output latency in clocks (0 = combinational).
- EARLY_EXIT, 1, when 1, abort remaining terms once overflow is seen.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset: synchronous, active-high.
- in_valid, input, 1, operand offered.
- in_ready, output, 1, controller can accept an operand.
- in_x, input, DATA_W, operand.
- out_valid, output, 1, result available.
- out_ready, input, 1, consumer accepts the result.
- out_sum, output, DATA_W, final accumulated sum.
- out_overflow, output, 1, sticky overflow for this operand.
- slc_x, output, DATA_W, to slice in_x.
- slc_num, output, DATA_W, to slice in_num.
- slc_sum, output, DATA_W, to slice in_sum.
- slc_addr, output, ADDR_W, to slice addr (term index).
- slc_sel_sum, output, 1, to slice sel_sum; high only on term 0 (start fresh accumulation).
- slc_overflow, output, 1, to slice in_overflow (registered sticky flag).
- slc_out_x, input, DATA_W, from slice out_x.
- slc_out_num, input, DATA_W, from slice out_num.
- slc_out_sum, input, DATA_W, from slice out_sum.
- slc_out_overflow, input, 1, from slice out_overflow.

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE.
- Reset values: state=IDLE; in_ready=1; out_valid=0; out_sum=0; out_overflow=0; all slc_* outputs=0; term counter=0; wait counter=0.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: x_reg←in_x, num_reg←in_x, sum_reg←0, ovf_reg←0, term←0; go to ISSUE.
- ISSUE:
  - One cycle.
  - Slice inputs driven from the registers: slc_addr=term, slc_sel_sum=(term==0).
  - If SLICE_LAT==0, capture this cycle; otherwise go to WAIT with wcnt←SLICE_LAT-1.
- WAIT:
  - Slice inputs held stable; wcnt decrements.
  - Capture when wcnt==0.
- Capture:
  - x_reg←slc_out_x, num_reg←slc_out_num, sum_reg←slc_out_sum, ovf_reg←ovf_reg|slc_out_overflow.
  - If term==TERMS-1, or (EARLY_EXIT and the new ovf_reg=1): go to DONE. Otherwise term←term+1 and return to ISSUE.
- DONE:
  - out_valid=1; out_sum=sum_reg and out_overflow=ovf_reg, both stable while out_valid&!out_ready.
  - On out_ready: return to IDLE.
  - in_ready=0 in every state except IDLE (no overlap of operands).
- Latency: out_valid rises TERMS*(SLICE_LAT+1)+1 clocks after the accept edge (full run).
- Early exit at term k: out_valid rises (k+1)*(SLICE_LAT+1)+1 clocks after the accept edge; out_sum is the sum captured at term k.
- Per-term rules:
  - slc_sel_sum is never high outside term 0.
  - slc_addr never exceeds TERMS-1.
  - The term counter does not wrap within an operand.
- Back-to-back: after out_valid&out_ready, in_ready is high the next cycle; no combinational in→out path.
- rst mid-operation: next cycle is IDLE with reset values; partial results are discarded and out_valid is not asserted.
- TERMS=1: one ISSUE (plus WAIT) pass, then DONE.

Decomposition:
- Shared package:
  - state enum (IDLE/ISSUE/WAIT/DONE);
  - DATA_W default;
  - Q1.31 constants ONE=32'h7FFFFFFF and NEG_HALF=32'hC0000000 for benches.
- No sub-module is needed. The slice stays external, and the top level instantiates pipe_slice_dp next to this controller.

Test Plan:
- Basic sequencing: TERMS=4, SLICE_LAT=0, in_x=32'h40000000, slice model without overflow -> slc_addr 0,1,2,3 on consecutive cycles; slc_sel_sum high only in the first ISSUE cycle; out_valid 5 clocks after accept; out_sum equals the model sum; out_overflow=0.
- Slice latency: SLICE_LAT=1, TERMS=4 -> each term holds the slice inputs 2 cycles; out_valid exactly 9 clocks after accept.
- Early exit: in_x=32'h7FFFFFFF, model overflows at term 1, EARLY_EXIT=1 -> out_valid after 2 terms (3 clocks at SLICE_LAT=0); out_overflow=1; slc_addr never reaches 2.
- No early exit: same stimulus with EARLY_EXIT=0 -> all 4 terms run; out_overflow=1 (sticky); slc_overflow high from term 2 onward.
- Backpressure and back-to-back: out_ready low 3 cycles -> out_sum/out_overflow stable and in_ready=0 throughout; on release, a second operand in_x=32'hC0000000 is accepted the following cycle.
- Mid-run reset: rst pulsed during term 2 -> next cycle in_ready=1, out_valid=0, all slc_* outputs=0; a fresh operand then completes normally.
